// File: rtl/fp_cmp_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fp_cmp_arbiter
//  Purpose  : Round-robin sharing of one pipelined FP compare unit among
//             NUM_REQ requesters, with an ID pipe that routes each done
//             pulse back to the requester that issued it.
//  Revision : 1.0 - initial release
// ============================================================================
module fp_cmp_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int LATENCY = 3,
   parameter int ID_W    = 2
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ*32-1:0]   req_a,
   input  logic [NUM_REQ*32-1:0]   req_b,
   output logic [NUM_REQ-1:0]      resp_valid,
   output logic [2:0]              resp_result,
   output logic                    cmp_go,
   output logic [31:0]             cmp_a,
   output logic [31:0]             cmp_b,
   input  logic                    cmp_done,
   input  logic [2:0]              cmp_result,
   output logic [2:0]              inflight,
   output logic                    err
);

   localparam int                   c_DRAIN_W    = $clog2(LATENCY + 2);
   localparam logic [c_DRAIN_W-1:0] c_DRAIN_INIT = c_DRAIN_W'(LATENCY + 1);

   logic [c_DRAIN_W-1:0] r_drain;
   logic [ID_W-1:0]      r_ptr;
   logic                 r_go;
   logic [31:0]          r_a;
   logic [31:0]          r_b;
   logic [ID_W-1:0]      r_issue_id;
   logic [LATENCY-1:0]   r_pv;
   logic [ID_W-1:0]      r_pid [LATENCY];
   logic [2:0]           r_inflight;
   logic                 r_err;

   logic                 w_drained;
   logic                 w_any;
   logic                 w_any_hi;
   logic [ID_W-1:0]      w_id_lo;
   logic [ID_W-1:0]      w_id_hi;
   logic [ID_W-1:0]      w_grant_id;
   logic [NUM_REQ-1:0]   w_ready;
   logic                 w_hs;
   logic [31:0]          w_sel_a;
   logic [31:0]          w_sel_b;
   logic                 w_head_v;
   logic [ID_W-1:0]      w_head_id;
   logic                 w_retire;

   // Stale comparator triggers are flushed while the drain counter runs.
   assign w_drained = (r_drain == '0);

   // Round-robin search: lowest valid index at/above ptr, else lowest overall.
   always_comb begin
      w_any    = 1'b0;
      w_any_hi = 1'b0;
      w_id_lo  = '0;
      w_id_hi  = '0;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (req_valid[j]) begin
            w_any   = 1'b1;
            w_id_lo = ID_W'(j);
            if (j >= int'(r_ptr)) begin
               w_any_hi = 1'b1;
               w_id_hi  = ID_W'(j);
            end
         end
      end
      w_grant_id = w_any_hi ? w_id_hi : w_id_lo;
   end

   // One-hot grant, suppressed during drain or when disabled.
   always_comb begin
      w_ready = '0;
      if (w_drained && enable && w_any) begin
         w_ready[w_grant_id] = 1'b1;
      end
   end

   assign w_hs      = |(w_ready & req_valid);
   assign req_ready = w_ready;

   // Operand mux for the granted requester.
   always_comb begin
      w_sel_a = '0;
      w_sel_b = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (ID_W'(j) == w_grant_id) begin
            w_sel_a = req_a[j*32 +: 32];
            w_sel_b = req_b[j*32 +: 32];
         end
      end
   end

   // Drain counter and round-robin pointer.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_drain <= c_DRAIN_INIT;
         r_ptr   <= '0;
      end else begin
         if (!w_drained) begin
            r_drain <= r_drain - 1'b1;
         end
         if (w_hs) begin
            r_ptr <= (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_id + 1'b1;
         end
      end
   end

   // Issue stage: registered go pulse; operands hold between issues.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_go       <= 1'b0;
         r_a        <= '0;
         r_b        <= '0;
         r_issue_id <= '0;
      end else begin
         r_go <= w_hs;
         if (w_hs) begin
            r_a        <= w_sel_a;
            r_b        <= w_sel_b;
            r_issue_id <= w_grant_id;
         end
      end
   end

   assign cmp_go = r_go;
   assign cmp_a  = r_a;
   assign cmp_b  = r_b;

   // ID pipe tracks the comparator pipe so the head lines up with cmp_done.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_pv <= '0;
         for (int k = 0; k < LATENCY; k++) begin
            r_pid[k] <= '0;
         end
      end else begin
         r_pv[0]  <= r_go;
         r_pid[0] <= r_issue_id;
         for (int k = 1; k < LATENCY; k++) begin
            r_pv[k]  <= r_pv[k-1];
            r_pid[k] <= r_pid[k-1];
         end
      end
   end

   assign w_head_v  = r_pv[LATENCY-1];
   assign w_head_id = r_pid[LATENCY-1];
   assign w_retire  = w_drained & cmp_done & w_head_v;

   // Route the result strobe to the requester recorded at the pipe head.
   always_comb begin
      resp_valid  = '0;
      resp_result = '0;
      if (w_retire) begin
         resp_valid[w_head_id] = 1'b1;
         resp_result           = cmp_result;
      end
   end

   // Outstanding-op counter and sticky done/pipe disagreement flag.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_inflight <= '0;
         r_err      <= 1'b0;
      end else begin
         case ({w_hs, w_retire})
            2'b10:   r_inflight <= r_inflight + 1'b1;
            2'b01:   r_inflight <= r_inflight - 1'b1;
            default: r_inflight <= r_inflight;
         endcase
         if (w_drained && (cmp_done != w_head_v)) begin
            r_err <= 1'b1;
         end
      end
   end

   assign inflight = r_inflight;
   assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fp_cmp_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_cmp_arbiter
//  Purpose  : Directed self-checking bench for fp_cmp_arbiter with a
//             3-cycle behavioural comparator that has no reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fp_cmp_arbiter;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          enable = 1'b0;
   logic [3:0]    req_valid = '0;
   logic [3:0]    req_ready;
   logic [127:0]  req_a = '0;
   logic [127:0]  req_b = '0;
   logic [3:0]    resp_valid;
   logic [2:0]    resp_result;
   logic          cmp_go;
   logic [31:0]   cmp_a;
   logic [31:0]   cmp_b;
   logic          cmp_done;
   logic [2:0]    cmp_result;
   logic [2:0]    inflight;
   logic          err;

   int n_cmp = 0;
   int n_bad = 0;

   // Expected comparator result per requester ({lt,eq,gt}) for the operand table.
   logic [2:0] res_tab [4] = '{3'b010, 3'b001, 3'b100, 3'b001};

   logic       inj = 1'b0;
   logic [2:0] m_v = '0;
   logic [2:0] m_r [3] = '{default: 3'b000};

   fp_cmp_arbiter #(.NUM_REQ(4), .LATENCY(3), .ID_W(2)) dut (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a       (req_a),
      .req_b       (req_b),
      .resp_valid  (resp_valid),
      .resp_result (resp_result),
      .cmp_go      (cmp_go),
      .cmp_a       (cmp_a),
      .cmp_b       (cmp_b),
      .cmp_done    (cmp_done),
      .cmp_result  (cmp_result),
      .inflight    (inflight),
      .err         (err)
   );

   always #5 clock = ~clock;

   // Float ordering for non-NaN operands, result as {lt,eq,gt}.
   function automatic logic [2:0] fcmp(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] ka;
      logic [31:0] kb;
      ka = a[31] ? ~a : (a | 32'h8000_0000);
      kb = b[31] ? ~b : (b | 32'h8000_0000);
      if (ka < kb)       return 3'b100;
      else if (ka == kb) return 3'b010;
      else               return 3'b001;
   endfunction

   // Behavioural comparator: fixed 3-cycle go-to-done, never reset.
   always @(posedge clock) begin
      m_v    <= {m_v[1:0], cmp_go};
      m_r[0] <= fcmp(cmp_a, cmp_b);
      m_r[1] <= m_r[0];
      m_r[2] <= m_r[1];
   end

   assign cmp_done   = m_v[2] | inj;
   assign cmp_result = m_r[2];

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset     = 1'b0;
      enable    = 1'b1;
      req_valid = '0;
      req_a[31:0]   = 32'h3F80_0000; req_b[31:0]   = 32'h3F80_0000;
      req_a[63:32]  = 32'h4000_0000; req_b[63:32]  = 32'h3F80_0000;
      req_a[95:64]  = 32'h3F80_0000; req_b[95:64]  = 32'h4000_0000;
      req_a[127:96] = 32'hC000_0000; req_b[127:96] = 32'hC040_0000;
      repeat (3) @(posedge clock);
      @(negedge clock);
      n_cmp++;
      if (cmp_go !== 1'b0 || cmp_a !== 32'h0 || cmp_b !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_issue: go=%b a=%h b=%h, required go=0 a=0 b=0", cmp_go, cmp_a, cmp_b);
      end
      n_cmp++;
      if (inflight !== 3'd0 || err !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_state: inflight=%0d err=%b, required 0/0", inflight, err);
      end
      n_cmp++;
      if (req_ready !== 4'b0 || resp_valid !== 4'b0) begin
         n_bad++;
         $display("FAIL reset_handshake: ready=%b resp=%b, required 0000/0000", req_ready, resp_valid);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] e_rdy;
      logic [3:0] e_rsp;
      logic [2:0] e_res;
      logic [2:0] e_inf;
      next_cycle();
      reset     = 1'b1;
      req_valid = 4'b1111;
      for (int c = 0; c <= 16; c++) begin
         if (c > 0) next_cycle();
         if (c == 9) req_valid = 4'b0000;
         @(negedge clock);
         e_rdy = (c >= 4 && c <= 8) ? (4'b0001 << ((c - 4) % 4)) : 4'b0000;
         e_rsp = (c >= 8 && c <= 12) ? (4'b0001 << ((c - 8) % 4)) : 4'b0000;
         e_res = (c >= 8 && c <= 12) ? res_tab[(c - 8) % 4] : 3'b000;
         case (c)
            5:       e_inf = 3'd1;
            6:       e_inf = 3'd2;
            7:       e_inf = 3'd3;
            8, 9:    e_inf = 3'd4;
            10:      e_inf = 3'd3;
            11:      e_inf = 3'd2;
            12:      e_inf = 3'd1;
            default: e_inf = 3'd0;
         endcase
         n_cmp++;
         if (req_ready !== e_rdy) begin
            n_bad++;
            $display("FAIL rr_ready c=%0d: got %b, required %b", c, req_ready, e_rdy);
         end
         n_cmp++;
         if (resp_valid !== e_rsp || resp_result !== e_res) begin
            n_bad++;
            $display("FAIL rr_resp c=%0d: got %b/%b, required %b/%b", c, resp_valid, resp_result, e_rsp, e_res);
         end
         n_cmp++;
         if (inflight !== e_inf) begin
            n_bad++;
            $display("FAIL rr_inflight c=%0d: got %0d, required %0d", c, inflight, e_inf);
         end
      end
      n_cmp++;
      if (err !== 1'b0) begin
         n_bad++;
         $display("FAIL rr_err: got %b, required 0", err);
      end
   endtask

   task automatic test_single();
      logic [3:0] e_rsp;
      logic [2:0] e_res;
      logic [2:0] e_inf;
      for (int c = 0; c <= 6; c++) begin
         next_cycle();
         req_valid = (c == 0) ? 4'b0100 : 4'b0000;
         @(negedge clock);
         e_rsp = (c == 4) ? 4'b0100 : 4'b0000;
         e_res = (c == 4) ? 3'b100 : 3'b000;
         e_inf = (c >= 1 && c <= 4) ? 3'd1 : 3'd0;
         n_cmp++;
         if (req_ready !== ((c == 0) ? 4'b0100 : 4'b0000)) begin
            n_bad++;
            $display("FAIL single_ready c=%0d: got %b", c, req_ready);
         end
         n_cmp++;
         if (cmp_go !== (c == 1)) begin
            n_bad++;
            $display("FAIL single_go c=%0d: got %b, required %b", c, cmp_go, (c == 1));
         end
         if (c == 1) begin
            n_cmp++;
            if (cmp_a !== 32'h3F80_0000 || cmp_b !== 32'h4000_0000) begin
               n_bad++;
               $display("FAIL single_operands: got %h/%h, required 3f800000/40000000", cmp_a, cmp_b);
            end
         end
         n_cmp++;
         if (resp_valid !== e_rsp || resp_result !== e_res) begin
            n_bad++;
            $display("FAIL single_resp c=%0d: got %b/%b, required %b/%b", c, resp_valid, resp_result, e_rsp, e_res);
         end
         n_cmp++;
         if (inflight !== e_inf) begin
            n_bad++;
            $display("FAIL single_inflight c=%0d: got %0d, required %0d", c, inflight, e_inf);
         end
      end
   endtask

   task automatic test_wrap();
      logic [3:0] e_rdy;
      logic [3:0] e_rsp;
      logic [2:0] e_res;
      for (int c = 0; c <= 8; c++) begin
         next_cycle();
         case (c)
            0:       req_valid = 4'b0010;
            1:       req_valid = 4'b1010;
            2:       req_valid = 4'b0010;
            default: req_valid = 4'b0000;
         endcase
         @(negedge clock);
         case (c)
            0, 2:    e_rdy = 4'b0010;
            1:       e_rdy = 4'b1000;
            default: e_rdy = 4'b0000;
         endcase
         case (c)
            4, 6:    e_rsp = 4'b0010;
            5:       e_rsp = 4'b1000;
            default: e_rsp = 4'b0000;
         endcase
         e_res = (c >= 4 && c <= 6) ? 3'b001 : 3'b000;
         n_cmp++;
         if (req_ready !== e_rdy) begin
            n_bad++;
            $display("FAIL wrap_ready c=%0d: got %b, required %b", c, req_ready, e_rdy);
         end
         n_cmp++;
         if (resp_valid !== e_rsp || resp_result !== e_res) begin
            n_bad++;
            $display("FAIL wrap_resp c=%0d: got %b/%b, required %b/%b", c, resp_valid, resp_result, e_rsp, e_res);
         end
      end
   endtask

   task automatic test_enable_drop();
      logic [3:0] e_rdy;
      logic [3:0] e_rsp;
      logic [2:0] e_res;
      logic [2:0] e_inf;
      for (int c = 0; c <= 9; c++) begin
         next_cycle();
         req_valid = 4'b1111;
         enable    = (c < 3);
         @(negedge clock);
         case (c)
            0:       e_rdy = 4'b0100;
            1:       e_rdy = 4'b1000;
            2:       e_rdy = 4'b0001;
            default: e_rdy = 4'b0000;
         endcase
         case (c)
            4:       begin e_rsp = 4'b0100; e_res = 3'b100; end
            5:       begin e_rsp = 4'b1000; e_res = 3'b001; end
            6:       begin e_rsp = 4'b0001; e_res = 3'b010; end
            default: begin e_rsp = 4'b0000; e_res = 3'b000; end
         endcase
         case (c)
            1:       e_inf = 3'd1;
            2:       e_inf = 3'd2;
            3, 4:    e_inf = 3'd3;
            5:       e_inf = 3'd2;
            6:       e_inf = 3'd1;
            default: e_inf = 3'd0;
         endcase
         n_cmp++;
         if (req_ready !== e_rdy) begin
            n_bad++;
            $display("FAIL en_ready c=%0d: got %b, required %b", c, req_ready, e_rdy);
         end
         n_cmp++;
         if (resp_valid !== e_rsp || resp_result !== e_res) begin
            n_bad++;
            $display("FAIL en_resp c=%0d: got %b/%b, required %b/%b", c, resp_valid, resp_result, e_rsp, e_res);
         end
         n_cmp++;
         if (inflight !== e_inf) begin
            n_bad++;
            $display("FAIL en_inflight c=%0d: got %0d, required %0d", c, inflight, e_inf);
         end
      end
      n_cmp++;
      if (err !== 1'b0) begin
         n_bad++;
         $display("FAIL en_err: got %b, required 0", err);
      end
      next_cycle();
      req_valid = 4'b0000;
      enable    = 1'b1;
   endtask

   task automatic test_reset_midstream();
      logic [3:0] e_rdy;
      logic [3:0] e_rsp;
      logic [2:0] e_res;
      for (int c = 0; c <= 14; c++) begin
         next_cycle();
         req_valid = (c <= 9) ? 4'b1111 : 4'b0000;
         if (c == 4) reset = 1'b0;
         if (c == 5) reset = 1'b1;
         @(negedge clock);
         case (c)
            0:       e_rdy = 4'b0010;
            1:       e_rdy = 4'b0100;
            2:       e_rdy = 4'b1000;
            3, 9:    e_rdy = 4'b0001;
            default: e_rdy = 4'b0000;
         endcase
         e_rsp = (c == 13) ? 4'b0001 : 4'b0000;
         e_res = (c == 13) ? 3'b010 : 3'b000;
         n_cmp++;
         if (req_ready !== e_rdy) begin
            n_bad++;
            $display("FAIL rstmid_ready c=%0d: got %b, required %b", c, req_ready, e_rdy);
         end
         n_cmp++;
         if (resp_valid !== e_rsp || resp_result !== e_res) begin
            n_bad++;
            $display("FAIL rstmid_resp c=%0d: got %b/%b, required %b/%b", c, resp_valid, resp_result, e_rsp, e_res);
         end
         n_cmp++;
         if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_err c=%0d: got %b, required 0", c, err);
         end
         if (c == 4 || c == 14) begin
            n_cmp++;
            if (inflight !== 3'd0) begin
               n_bad++;
               $display("FAIL rstmid_inflight c=%0d: got %0d, required 0", c, inflight);
            end
         end
      end
   endtask

   task automatic test_spurious_done();
      next_cycle();
      inj = 1'b1;
      @(negedge clock);
      n_cmp++;
      if (err !== 1'b0 || resp_valid !== 4'b0000) begin
         n_bad++;
         $display("FAIL spur_same_cycle: err=%b resp=%b, required 0/0000", err, resp_valid);
      end
      next_cycle();
      inj = 1'b0;
      @(negedge clock);
      n_cmp++;
      if (err !== 1'b1) begin
         n_bad++;
         $display("FAIL spur_set: err=%b, required 1", err);
      end
      repeat (100) @(posedge clock);
      @(negedge clock);
      n_cmp++;
      if (err !== 1'b1 || inflight !== 3'd0) begin
         n_bad++;
         $display("FAIL spur_sticky: err=%b inflight=%0d, required 1/0", err, inflight);
      end
      next_cycle();
      reset = 1'b0;
      @(negedge clock);
      n_cmp++;
      if (err !== 1'b0) begin
         n_bad++;
         $display("FAIL spur_clear: err=%b, required 0", err);
      end
      next_cycle();
      reset = 1'b1;
      repeat (6) @(posedge clock);
      @(negedge clock);
      n_cmp++;
      if (err !== 1'b0) begin
         n_bad++;
         $display("FAIL spur_after_reset: err=%b, required 0", err);
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single();
      test_wrap();
      test_enable_drop();
      test_reset_midstream();
      test_spurious_done();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
